// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 keyboard stimulus block.
package ps2_pkg;

  // Sequencer and frame-engine states. The sequencer uses ST_BIT_HI as
  // "frame in flight"; the frame engine owns the real high/low split.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_BIT_HI = 3'd2,
    ST_BIT_LO = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int         FRAME_BITS = 11;
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  // Odd parity: the parity bit makes the count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Frame layout, bit 0 sent first: start(0), data LSB first, parity, stop(1).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit PS/2 device-to-host frame.
//
// Handshake: start is sampled only while idle (busy=0); the frame begins on
// the edge that samples it. finished is high for exactly the last cycle of the
// frame (final low phase of the stop bit), so the owner can react on the same
// edge at which the engine returns to idle with no dead cycle.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int DIVISOR = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       finished,
  output logic       ps2_clk,
  output logic       ps2_data
);

  state_t                  state;
  logic [15:0]             div_cnt;
  logic [3:0]              bit_idx;
  logic [FRAME_BITS-1:0]   frame_q;
  logic                    ps2_clk_q;
  logic                    ps2_data_q;

  logic                    div_last;
  logic                    bit_last;
  logic [3:0]              next_idx;
  logic [FRAME_BITS-1:0]   frame_next;

  // Phase/bit terminal counts and the frame to load on start.
  always_comb begin
    div_last   = (div_cnt == 16'(DIVISOR - 1));
    bit_last   = (bit_idx == 4'(FRAME_BITS - 1));
    next_idx   = bit_idx + 4'd1;
    frame_next = build_frame(data);
  end

  // Bit-timing FSM; data only moves together with the clock going high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_idx    <= '0;
      frame_q    <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            frame_q    <= frame_next;
            bit_idx    <= '0;
            div_cnt    <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= frame_next[0];
            state      <= ST_BIT_HI;
          end
        end
        ST_BIT_HI: begin
          if (div_last) begin
            div_cnt   <= '0;
            ps2_clk_q <= 1'b0;
            state     <= ST_BIT_LO;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        ST_BIT_LO: begin
          if (div_last) begin
            div_cnt   <= '0;
            ps2_clk_q <= 1'b1;
            if (bit_last) begin
              ps2_data_q <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              bit_idx    <= next_idx;
              ps2_data_q <= frame_q[next_idx];
              state      <= ST_BIT_HI;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          ps2_clk_q  <= 1'b1;
          ps2_data_q <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign finished = (state == ST_BIT_LO) && div_last && bit_last;
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;

endmodule

// File: rtl/ps2_kbd_stim.sv
// PS/2 keyboard (device side) stimulus source: on a rising edge of i_request
// it sends a make (and optionally break) scancode sequence, each byte
// preceded by DELAY idle cycles, then pulses o_done for one cycle.
module ps2_kbd_stim
  import ps2_pkg::*;
#(
  parameter int         DIVISOR    = 2,
  parameter int         DELAY      = 20,
  parameter logic [7:0] SCANCODE   = 8'h3E,
  parameter int         SEND_BREAK = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_request,
  output logic o_ps2_clk,
  output logic o_ps2_data,
  output logic o_done
);

  // Index of the final byte: make/F0/make, or make alone.
  localparam logic [1:0] LAST_BYTE = (SEND_BREAK != 0) ? 2'd2 : 2'd0;

  state_t      state;
  logic        req_q;
  logic [15:0] wait_cnt;
  logic [1:0]  byte_idx;
  logic        done_q;

  logic        req_edge;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        tx_finished;
  logic        tx_clk;
  logic        tx_data;

  // Request edge, end of the pre-byte delay, and the byte to send next.
  always_comb begin
    req_edge = i_request & ~req_q;
    tx_start = (state == ST_WAIT) && (wait_cnt == 16'(DELAY - 1)) && !tx_busy;
    tx_byte  = (byte_idx == 2'd1) ? BREAK_CODE : SCANCODE;
  end

  // Sequencer: delay, hand a byte to the frame engine, repeat, then done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      req_q    <= 1'b0;
      wait_cnt <= '0;
      byte_idx <= '0;
      done_q   <= 1'b0;
    end else begin
      req_q  <= i_request;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_edge) begin
            wait_cnt <= '0;
            byte_idx <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx_start) begin
            wait_cnt <= '0;
            state    <= ST_BIT_HI;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_BIT_HI: begin
          if (tx_finished) begin
            if (byte_idx == LAST_BYTE) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              wait_cnt <= '0;
              state    <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          // Edges seen here are dropped; only IDLE accepts a request.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  ps2_frame_tx #(
    .DIVISOR (DIVISOR)
  ) u_frame_tx (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (tx_start),
    .data     (tx_byte),
    .busy     (tx_busy),
    .finished (tx_finished),
    .ps2_clk  (tx_clk),
    .ps2_data (tx_data)
  );

  assign o_ps2_clk  = tx_clk;
  assign o_ps2_data = tx_data;
  assign o_done     = done_q;

endmodule

// File: tb/tb_ps2_kbd_stim.sv
// Testbench for ps2_kbd_stim: a default instance (3E/F0/3E, DIVISOR=2,
// DELAY=20) and a fast single-byte instance (16, DIVISOR=1, DELAY=1).
// Expected frames and done cycles are queued at stimulus time; a monitor
// decodes frames on PS/2 clock falling edges and checks them.
module tb_ps2_kbd_stim;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_v = 2'b11;
  logic [1:0] req_v = 2'b00;
  wire  [1:0] c_v;
  wire  [1:0] d_v;
  wire  [1:0] done_v;

  ps2_kbd_stim u_dut_a (
    .i_clk      (clk),
    .i_rst      (rst_v[0]),
    .i_request  (req_v[0]),
    .o_ps2_clk  (c_v[0]),
    .o_ps2_data (d_v[0]),
    .o_done     (done_v[0])
  );

  ps2_kbd_stim #(
    .DIVISOR    (1),
    .DELAY      (1),
    .SCANCODE   (8'h16),
    .SEND_BREAK (0)
  ) u_dut_b (
    .i_clk      (clk),
    .i_rst      (rst_v[1]),
    .i_request  (req_v[1]),
    .o_ps2_clk  (c_v[1]),
    .o_ps2_data (d_v[1]),
    .o_done     (done_v[1])
  );

  // ---------------- scoreboard ----------------
  // exp_q entry: {dut, parity, byte}; exp_done_q entry: {dut, cycle}.
  logic [9:0]  exp_q[$];
  logic [32:0] exp_done_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int stab_err     = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [10:0] sh [2];
  int          nb [2];
  logic        pc [2];
  logic        pd [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sh[i] = '0; nb[i] = 0; pc[i] = 1'b1; pd[i] = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        nb[i] = 0;
        pc[i] = 1'b1;
        pd[i] = 1'b1;
      end else begin
        if (!pc[i] && !c_v[i] && (d_v[i] != pd[i])) stab_err++;
        if (pc[i] && !c_v[i]) begin
          sh[i][nb[i]] = d_v[i];
          nb[i]++;
          if (nb[i] == 11) begin
            nb[i] = 0;
            chk("start_bit", int'(sh[i][0]), 0);
            chk("stop_bit", int'(sh[i][10]), 1);
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", int'({i[0], sh[i][9:1]}), 0);
            end else begin
              chk("frame_byte_par", int'({i[0], sh[i][9:1]}), int'(exp_q.pop_front()));
            end
          end
        end
        if (done_v[i]) begin
          if (exp_done_q.size() == 0) begin
            chk("unexpected_done", i, -1);
          end else begin
            logic [32:0] e;
            e = exp_done_q.pop_front();
            chk("done_dut", i, int'(e[32]));
            chk("done_cycle", cyc, int'(e[31:0]));
          end
        end
        pc[i] = c_v[i];
        pd[i] = d_v[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  int t0;

  task automatic raise_req(input int id);
    @(negedge clk);
    req_v[id] = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic wait_first_fall(input int id, input int exp_lat);
    for (int k = 0; k < 200 && c_v[id]; k++) @(negedge clk);
    chk("first_fall_latency", cyc - t0, exp_lat);
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound && exp_done_q.size() != 0; k++) @(negedge clk);
    chk("done_seen", exp_done_q.size(), 0);
  endtask

  task automatic push_default_seq;
    exp_q.push_back({1'b0, 1'b0, 8'h3E});
    exp_q.push_back({1'b0, 1'b1, 8'hF0});
    exp_q.push_back({1'b0, 1'b0, 8'h3E});
    exp_done_q.push_back({1'b0, 32'(t0 + 192)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idle_err;

    // Reset state, sampled while reset is held.
    @(negedge clk);
    chk("rst_ps2_clk", int'(c_v), 3);
    chk("rst_ps2_data", int'(d_v), 3);
    chk("rst_done", int'(done_v), 0);
    repeat (2) @(negedge clk);
    rst_v = 2'b00;

    // No request: lines stay idle, no done.
    idle_err = 0;
    repeat (1000) begin
      @(negedge clk);
      if (c_v != 2'b11 || d_v != 2'b11 || done_v != 2'b00) idle_err++;
    end
    chk("idle_no_request", idle_err, 0);

    // Full default sequence, with a second request edge mid-frame.
    raise_req(0);
    push_default_seq();
    wait_first_fall(0, 22);
    while (cyc < t0 + 90) @(negedge clk);
    req_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    req_v[0] = 1'b1;
    wait_done(400);
    repeat (200) @(negedge clk);
    req_v[0] = 1'b0;
    chk("seq1_frames_left", exp_q.size(), 0);

    // Reset during the second byte: lines high at once, no done.
    repeat (3) @(negedge clk);
    raise_req(0);
    exp_q.push_back({1'b0, 1'b0, 8'h3E});
    while (cyc < t0 + 94) @(negedge clk);
    #2 rst_v[0] = 1'b1;
    #1;
    chk("async_rst_ps2_clk", int'(c_v[0]), 1);
    chk("async_rst_ps2_data", int'(d_v[0]), 1);
    chk("async_rst_done", int'(done_v[0]), 0);
    req_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0;
    repeat (300) @(negedge clk);
    chk("rst_frames_left", exp_q.size(), 0);

    // Fresh request after the reset gives a complete sequence.
    raise_req(0);
    push_default_seq();
    wait_done(400);
    req_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("seq2_frames_left", exp_q.size(), 0);

    // Fast single-byte instance.
    raise_req(1);
    exp_q.push_back({1'b1, 1'b0, 8'h16});
    exp_done_q.push_back({1'b1, 32'(t0 + 23)});
    wait_first_fall(1, 2);
    wait_done(100);
    req_v[1] = 1'b0;
    repeat (50) @(negedge clk);

    chk("data_stable_while_clk_low", stab_err, 0);
    chk("final_frames_left", exp_q.size(), 0);
    chk("final_done_left", exp_done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
